// File: rtl/sram_rd_ctrl.sv
// sram_rd_ctrl: issues one SRAM read per accepted beat address and buffers the results for the AXI4 R channel.
// Optional range check: define SRAM_RD_RANGE_CHK_EN to answer beats beyond SRAM_DEPTH with SLVERR.
module sram_rd_ctrl #(
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int SRAM_DEPTH      = 4096,
    localparam int SRAM_AW        = $clog2(SRAM_DEPTH)
) (
    input  logic                       aclk_i,
    input  logic                       aresetn_i,
    input  logic [AXI4_ADDR_WIDTH-1:0] addr_i,
    input  logic                       addr_last_i,
    input  logic                       addr_valid_i,
    output logic                       addr_ready_o,
    output logic                       sram_en_o,
    output logic [SRAM_AW-1:0]         sram_addr_o,
    input  logic [AXI4_DATA_WIDTH-1:0] sram_rdata_i,
    output logic [AXI4_DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]                 rresp_o,
    output logic                       rlast_o,
    output logic                       rvalid_o,
    input  logic                       rready_i
);
    localparam int BYTE_W = $clog2(AXI4_DATA_WIDTH / 8);
    localparam int WIDX_W = AXI4_ADDR_WIDTH - BYTE_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [WIDX_W-1:0]          widx;
    logic                       acc;
    logic                       err;
    logic                       push;
    logic                       pop;
    logic                       inflight_q;
    logic                       last_q;
    logic [CNT_W-1:0]           fifo_cnt;
    logic [CNT_W:0]             occupancy;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [AXI4_DATA_WIDTH-1:0] push_data;
    logic [1:0]                 push_resp;
    logic [AXI4_DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [1:0]                 resp_mem [FIFO_DEPTH];
    logic                       last_mem [FIFO_DEPTH];
    logic                       unused_bits;

    // Handshakes: a beat moves on any cycle where valid and ready are both high; addr_ready_o never
    // looks at addr_valid_i or rready_i, and the R head holds steady while rvalid_o & !rready_i.
    assign widx         = addr_i[AXI4_ADDR_WIDTH-1:BYTE_W];
    assign unused_bits  = ^{addr_i[BYTE_W-1:0], widx};
    assign occupancy    = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, inflight_q};
    assign addr_ready_o = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
    assign acc          = addr_valid_i & addr_ready_o;
    assign sram_en_o    = acc & ~err;
    assign sram_addr_o  = addr_valid_i ? widx[SRAM_AW-1:0] : '0;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            inflight_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            inflight_q <= acc;
            if (acc) last_q <= addr_last_i;
        end
    end

`ifdef SRAM_RD_RANGE_CHK_EN
    logic err_q;

    // Any set word-index bit above the SRAM address range is out of bounds.
    assign err = |widx[WIDX_W-1:SRAM_AW];

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) err_q <= 1'b0;
        else if (acc)   err_q <= err;
    end

    assign push_data = err_q ? '0 : sram_rdata_i;
    assign push_resp = err_q ? 2'b10 : 2'b00;
`else
    assign err       = 1'b0;
    assign push_data = sram_rdata_i;
    assign push_resp = 2'b00;
`endif

    // The credit rule on addr_ready_o guarantees a free slot for every push.
    assign push = inflight_q;
    assign pop  = rvalid_o & rready_i;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                resp_mem[i] <= '0;
                last_mem[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= push_data;
                resp_mem[wr_ptr] <= push_resp;
                last_mem[wr_ptr] <= last_q;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    assign rvalid_o = fifo_cnt != '0;
    assign rdata_o  = data_mem[rd_ptr];
    assign rresp_o  = resp_mem[rd_ptr];
    assign rlast_o  = last_mem[rd_ptr];
endmodule

// File: tb/tb_sram_rd_ctrl.sv
// Directed testbench for sram_rd_ctrl with an SRAM model and an expected-beat queue.
// Build with or without SRAM_RD_RANGE_CHK_EN; the range-check expectations follow the macro.
module tb_sram_rd_ctrl;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int FD  = 4;
    localparam int SD  = 4096;
    localparam int SAW = 12;

    logic           clk        = 1'b0;
    logic           rst_n      = 1'b0;
    logic [AW-1:0]  addr       = '0;
    logic           addr_last  = 1'b0;
    logic           addr_valid = 1'b0;
    logic           addr_ready;
    logic           sram_en;
    logic [SAW-1:0] sram_addr;
    logic [DW-1:0]  sram_rdata = '0;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           rvalid;
    logic           rready     = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int idx      = 0;
    logic [34:0] exp_q[$];

    always #5 clk = ~clk;

    sram_rd_ctrl #(
        .AXI4_ADDR_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .FIFO_DEPTH(FD), .SRAM_DEPTH(SD)
    ) dut (
        .aclk_i(clk), .aresetn_i(rst_n), .addr_i(addr), .addr_last_i(addr_last),
        .addr_valid_i(addr_valid), .addr_ready_o(addr_ready), .sram_en_o(sram_en),
        .sram_addr_o(sram_addr), .sram_rdata_i(sram_rdata), .rdata_o(rdata),
        .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid), .rready_i(rready)
    );

    function automatic logic [31:0] mem_val(input logic [11:0] a);
        if (a == 12'h010) return 32'hDEADBEEF;
        return {20'hCAFE0, a};
    endfunction

    function automatic logic [34:0] exp_entry(input logic [31:0] a, input logic l);
`ifdef SRAM_RD_RANGE_CHK_EN
        if (a[31:14] != '0) return {32'h0, 2'b10, l};
`endif
        return {mem_val(a[13:2]), 2'b00, l};
    endfunction

    // SRAM model: one-cycle read latency.
    always @(posedge clk) if (sram_en) sram_rdata <= mem_val(sram_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every R handshake must match the oldest expected beat.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (dut.inflight_q) check("push_room", 64'(dut.fifo_cnt < 3'(FD)), 64'(1));
            if (rvalid && rready)
                check("r_beat", 64'({1'b1, rdata, rresp, rlast}),
                      exp_q.size() != 0 ? 64'({1'b1, exp_q.pop_front()}) : 64'(0));
        end
    end

    // One driver cycle: offer beat idx of an n-beat sequence starting at base.
    task automatic step(input logic [31:0] base, input int n, input logic rr);
        @(negedge clk);
        rready = rr;
        if (idx < n) begin
            addr_valid = 1'b1;
            addr       = base + 32'(4 * idx);
            addr_last  = (idx == n - 1);
        end else begin
            addr_valid = 1'b0;
            addr       = '0;
            addr_last  = 1'b0;
        end
        #1;
        if (addr_valid && addr_ready) begin
            exp_q.push_back(exp_entry(addr, addr_last));
            idx++;
        end
    endtask

    task automatic drain;
        int k;
        k = 0;
        @(negedge clk);
        rready = 1'b1;
        addr_valid = 1'b0;
        addr = '0;
        addr_last = 1'b0;
        #3;
        while ((exp_q.size() != 0 || rvalid) && k < 60) begin
            @(negedge clk);
            #3;
            k++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        check("drain_rvalid", 64'(rvalid), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr_ready"}, 64'(addr_ready), 64'(1));
        check({tag, "_sram_en"}, 64'(sram_en), 64'(0));
        check({tag, "_sram_addr"}, 64'(sram_addr), 64'(0));
        check({tag, "_rvalid"}, 64'(rvalid), 64'(0));
        check({tag, "_rdata"}, 64'(rdata), 64'(0));
        check({tag, "_rresp"}, 64'(rresp), 64'(0));
        check({tag, "_rlast"}, 64'(rlast), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat: 0x40 -> word 0x10 -> 0xDEADBEEF at N+2
        idx = 0;
        step(32'h40, 1, 1'b1);
        check("single_sram_en", 64'(sram_en), 64'(1));
        check("single_sram_addr", 64'(sram_addr), 64'(12'h010));
        step(32'h40, 1, 1'b1);
        check("single_n1_rvalid", 64'(rvalid), 64'(0));
        check("single_n1_sram_en", 64'(sram_en), 64'(0));
        step(32'h40, 1, 1'b1);
        check("single_n2_rvalid", 64'(rvalid), 64'(1));
        check("single_n2_rdata", 64'(rdata), 64'(32'hDEADBEEF));
        check("single_n2_rlast", 64'(rlast), 64'(1));
        check("single_n2_rresp", 64'(rresp), 64'(0));
        drain();

        // 4-beat burst back-to-back, no bubbles
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            step(32'h0, 4, 1'b1);
            if (c < 4) check("burst_sram_en", 64'(sram_en), 64'(1));
            if (c >= 2 && c < 6) begin
                check("burst_rvalid", 64'(rvalid), 64'(1));
                check("burst_rlast", 64'(rlast), 64'(c == 5));
            end
            if (c == 6) check("burst_idle", 64'(rvalid), 64'(0));
        end
        drain();

        // Backpressure: 8 beats offered with rready low
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            step(32'h100, 8, 1'b0);
            if (c >= 2) check("bp_head", 64'({rvalid, rdata, rresp, rlast}), 64'({1'b1, exp_q[0]}));
        end
        check("bp_accepted", 64'(idx), 64'(4));
        check("bp_ready_low", 64'(addr_ready), 64'(0));
        step(32'h100, 8, 1'b1);
        check("bp_ready_pop_cycle", 64'(addr_ready), 64'(0));
        step(32'h100, 8, 1'b1);
        check("bp_ready_after_pop", 64'(addr_ready), 64'(1));
        for (int c = 0; c < 30 && idx < 8; c++) step(32'h100, 8, 1'b1);
        check("bp_all_accepted", 64'(idx), 64'(8));
        drain();

        // Three buffered plus one in flight, then simultaneous push/pop and pointer wrap
        idx = 0;
        for (int c = 0; c < 4; c++) step(32'h200, 12, 1'b0);
        step(32'h200, 12, 1'b1);
        check("pp_cnt_3", 64'(dut.fifo_cnt), 64'(3));
        check("pp_inflight", 64'(dut.inflight_q), 64'(1));
        check("pp_ready_low", 64'(addr_ready), 64'(0));
        step(32'h200, 12, 1'b1);
        check("pp_cnt_hold", 64'(dut.fifo_cnt), 64'(3));
        check("pp_ready_back", 64'(addr_ready), 64'(1));
        begin
            logic [7:0] pat;
            pat = 8'b1101_0110;
            for (int c = 0; c < 60 && idx < 12; c++) begin
                step(32'h200, 12, pat[c % 8]);
                check("pp_cnt_le_depth", 64'(dut.fifo_cnt <= 3'(FD)), 64'(1));
            end
        end
        check("pp_all_accepted", 64'(idx), 64'(12));
        drain();

        // Address 0x4000 is out of range with the check on, aliases to word 0 without it
        idx = 0;
        step(32'h4000, 1, 1'b1);
`ifdef SRAM_RD_RANGE_CHK_EN
        check("range_sram_en", 64'(sram_en), 64'(0));
`else
        check("range_sram_en", 64'(sram_en), 64'(1));
        check("range_sram_addr", 64'(sram_addr), 64'(0));
`endif
        step(32'h4000, 1, 1'b1);
        step(32'h4000, 1, 1'b1);
        check("range_rvalid", 64'(rvalid), 64'(1));
`ifdef SRAM_RD_RANGE_CHK_EN
        check("range_rdata", 64'(rdata), 64'(0));
        check("range_rresp", 64'(rresp), 64'(2'b10));
`else
        check("range_rdata", 64'(rdata), 64'(32'hCAFE0000));
        check("range_rresp", 64'(rresp), 64'(0));
`endif
        check("range_rlast", 64'(rlast), 64'(1));
        drain();

        // Reset with two beats buffered and one in flight
        idx = 0;
        for (int c = 0; c < 4; c++) step(32'h300, 3, 1'b0);
        check("rst_pre_cnt", 64'(dut.fifo_cnt), 64'(2));
        check("rst_pre_inflight", 64'(dut.inflight_q), 64'(1));
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        idx = 0;
        step(32'h48, 1, 1'b1);
        check("post_rst_sram_addr", 64'(sram_addr), 64'(12'h012));
        step(32'h48, 1, 1'b1);
        step(32'h48, 1, 1'b1);
        check("post_rst_rvalid", 64'(rvalid), 64'(1));
        check("post_rst_rdata", 64'(rdata), 64'(32'hCAFE0012));
        check("post_rst_rlast", 64'(rlast), 64'(1));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_rd_ctrl.md
# sram_rd_ctrl

Read-data stage that sits directly downstream of the AXI4 burst address generator in the SRAM slave. It takes one beat address at a time over a valid/ready handshake and issues a single-cycle SRAM read for each beat. The returned word, its `last` flag and its response code go into a small FIFO that drives the AXI4 R channel. Credit accounting guarantees every issued read has a FIFO slot, so `rready_i` backpressure never drops data.

## Interface
- `FIFO_DEPTH`, 4: R-channel buffer entries; power of two, ≥2. Full throughput requires ≥3.
- `SRAM_DEPTH`, 4096: SRAM words; power of two. `SRAM_AW = $clog2(SRAM_DEPTH)`.
- `aclk_i` in 1: clock.
- `aresetn_i` in 1: reset, asynchronous, active-low.
- `addr_i` in `AXI4_ADDR_WIDTH`: byte address of the current beat.
- `addr_last_i` in 1: current beat is the last of its burst.
- `addr_valid_i` in 1: beat address valid.
- `addr_ready_o` out 1: stage accepts a beat.
- `sram_en_o` out 1: SRAM read strobe.
- `sram_addr_o` out `SRAM_AW`: SRAM word address.
- `sram_rdata_i` in `AXI4_DATA_WIDTH`: SRAM read data, valid the cycle after `sram_en_o`.
- `rdata_o` out `AXI4_DATA_WIDTH`: R data.
- `rresp_o` out 2: R response.
- `rlast_o` out 1: R last.
- `rvalid_o` out 1: R valid.
- `rready_i` in 1: R ready.

## Operation
- Word index `widx = addr_i[AXI4_ADDR_WIDTH-1 : $clog2(AXI4_DATA_WIDTH/8)]`. `sram_addr_o = widx[SRAM_AW-1:0]`.
- Accept: `acc = addr_valid_i & addr_ready_o`. `addr_ready_o = (fifo_cnt + inflight_q) < FIFO_DEPTH`. `addr_ready_o` is independent of `rready_i` and of `addr_valid_i`.
- `sram_en_o = acc`, combinational, in the same cycle as the accept. A non-error access is `sram_en_o` = 1. An error access holds `sram_en_o` at 0.
- Pipeline register, updated every cycle: `inflight_q <= acc`. `last_q` and `err_q` are captured from the accepted beat.
- Push, when `inflight_q` = 1: write `{err_q ? '0 : sram_rdata_i, err_q ? 2'b10 : 2'b00, last_q}`.
- Pop, on `rvalid_o & rready_i`.
- `rvalid_o = fifo_cnt != 0`. `rdata_o`, `rresp_o` and `rlast_o` show the FIFO head.
- Counter `fifo_cnt` has width `$clog2(FIFO_DEPTH)+1`. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- Push never hits a full FIFO, by construction of the credit rule. The bench asserts this.
- `rlast_o` is a pure pass-through of `addr_last_i`. The block does no burst counting.
- Reset mid-burst: all state clears asynchronously. In-flight and buffered beats are discarded. Upstream must reset together with this block.

## Timing
- Reset values: `addr_ready_o` = 1, `sram_en_o` = 0, `sram_addr_o` = 0 (driven 0 while `addr_valid_i` = 0 after reset), `rvalid_o` = 0, `rdata_o` = 0, `rresp_o` = 0, `rlast_o` = 0. FIFO storage and pointers reset to 0.
- Latency: accept in cycle N → `sram_en_o` in N → FIFO push at the end of N+1 → `rvalid_o` high in N+2.
- Throughput with `rready_i` held at 1 and `FIFO_DEPTH` ≥ 3: one beat per cycle, no bubbles.
- Backpressure: with `rready_i` = 0, at most `FIFO_DEPTH` beats are accepted, then `addr_ready_o` = 0. `addr_ready_o` returns to 1 in the cycle after the first pop.
- R channel rule: once `rvalid_o` = 1 and `rready_i` = 0, the head data, resp and last stay stable.

## Configuration
- `SRAM_RD_RANGE_CHK_EN` defined:
  - `err = widx >= SRAM_DEPTH`.
  - An erroneous beat sets `sram_en_o` = 0, returns `rdata_o` = 0 and `rresp_o` = 2'b10 (SLVERR), and still occupies a slot and preserves `rlast_o`.
- `SRAM_RD_RANGE_CHK_EN` undefined:
  - `err` is tied to 0 and `rresp_o` is always 2'b00.
  - Upper `widx` bits are ignored, so the address aliases modulo `SRAM_DEPTH`.
  - The `err_q` register is not instantiated.

## Test plan
- Single beat: `addr_i`=0x40, `addr_last_i`=1, `rready_i`=1, SRAM model returns 0xDEADBEEF for word 0x10 (32-bit data) → `sram_en_o` at N with `sram_addr_o`=0x10; `rvalid_o`, `rlast_o` and 0xDEADBEEF at N+2; `rresp_o`=0.
- 4-beat INCR burst (0x0, 0x4, 0x8, 0xC) back-to-back with `rready_i`=1 → four consecutive `rvalid_o` cycles; `rlast_o` only on the 4th beat; no idle cycle between beats.
- Backpressure: `rready_i`=0, eight beats offered → exactly 4 accepted, then `addr_ready_o`=0 and the head stays stable. Then `rready_i`=1 → all 8 beats arrive in order with correct data and no loss.
- Simultaneous push and pop with the FIFO at 3 entries plus 1 in flight → `fifo_cnt` stays 3 or 4 and never overflows (assertion). Pointers wrap past entry 3 correctly.
- Range check (macro on, `SRAM_DEPTH`=4096): `addr_i`=0x4000 → `sram_en_o` stays 0; R beat has `rdata_o`=0 and `rresp_o`=2'b10. With the macro off, the same address reads word 0 with `rresp_o`=0.
- Reset mid-burst: assert `aresetn_i` with 2 beats buffered and 1 in flight → all outputs at reset values immediately; after release, a new single beat completes normally.
